// File: rtl/fft_load_ctrl.sv
// Input-side frame loader: streams samples into the FFT sample buffer
// using an external flex counter, then hands the frame to the FFT core.
//
// Ports:
//   clk, n_rst                      clock, async active-low reset
//   start, frame_len, abort         frame control
//   in_valid, in_data, in_ready     upstream sample handshake
//   cnt_clear, cnt_enable,
//   cnt_rollover_val                drive the external flex counter
//   cnt_value, cnt_rollover_flag    counter state (write index, frame full)
//   wr_en, wr_addr, wr_data         sample buffer write port
//   fft_busy                        FFT core still busy with last frame
//   frame_done, busy, err_len       status outputs
module fft_load_ctrl #(
    parameter int NUM_CNT_BITS = 4,
    parameter int DATA_W       = 16
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_CNT_BITS-1:0] frame_len,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic                    cnt_clear,
    output logic                    cnt_enable,
    output logic [NUM_CNT_BITS-1:0] cnt_rollover_val,
    input  logic [NUM_CNT_BITS-1:0] cnt_value,
    input  logic                    cnt_rollover_flag,
    output logic                    wr_en,
    output logic [NUM_CNT_BITS-1:0] wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    input  logic                    fft_busy,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    err_len
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HANDOFF,
        DONE
    } state_t;

    state_t                  state_q;
    logic [NUM_CNT_BITS-1:0] len_q;
    logic                    err_len_q;
    logic                    len_ok;
    logic                    hs;

    assign len_ok = (frame_len != '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            err_len_q <= 1'b0;
        end else begin
            err_len_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && len_ok) begin
                            len_q   <= frame_len;
                            state_q <= LOAD;
                        end else if (start) begin
                            err_len_q <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (cnt_rollover_flag) state_q <= HANDOFF;
                    end
                    HANDOFF: begin
                        if (!fft_busy) state_q <= DONE;
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Ready drops during abort so upstream never sees a sample swallowed.
    assign in_ready = (state_q == LOAD) && !cnt_rollover_flag && !abort;
    assign hs       = in_valid && in_ready;

    assign wr_en      = hs;
    assign cnt_enable = hs;
    assign wr_addr    = cnt_value;
    assign wr_data    = in_data;

    // Counter is cleared against the incoming length while still IDLE.
    assign cnt_clear = abort || ((state_q == IDLE) && start && len_ok);
    assign cnt_rollover_val = (state_q == IDLE) ? frame_len : len_q;

    assign frame_done = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign err_len    = err_len_q;

endmodule
